// File: rtl/matrix_mem_pkg.sv
// Shared types and helpers for the matrix stream memory: engine states,
// traversal order encodings and width helpers.
package matrix_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } eng_state_t;

  localparam logic ORDER_ROW = 1'b0;
  localparam logic ORDER_COL = 1'b1;

  // Element address width, kept at least 1 bit for degenerate 1x1 shapes.
  function automatic int addr_w(input int m, input int n);
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/matrix_addr_gen.sv
// Row/column counters for the stream engine; walks r*N+c in row-major or
// column-major order and flags the final element (M-1, N-1).
module matrix_addr_gen
  import matrix_mem_pkg::*;
#(
  parameter  int M  = 8,
  parameter  int N  = 8,
  localparam int AW = addr_w(M, N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          transpose,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int RW = cnt_w(M);
  localparam int CW = cnt_w(N);

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          mode;
  logic          r_end;
  logic          c_end;

  assign r_end = (r == RW'(M - 1));
  assign c_end = (c == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r    <= '0;
      c    <= '0;
      mode <= ORDER_ROW;
    end else if (clear) begin
      r    <= '0;
      c    <= '0;
      mode <= transpose;
    end else if (advance) begin
      if (mode == ORDER_ROW) begin
        c <= c_end ? '0 : c + 1'b1;
        if (c_end) r <= r_end ? '0 : r + 1'b1;
      end else begin
        r <= r_end ? '0 : r + 1'b1;
        if (r_end) c <= c_end ? '0 : c + 1'b1;
      end
    end
  end

  // Both traversal orders finish on the bottom-right element.
  assign addr = AW'(r) * AW'(N) + AW'(c);
  assign last = r_end & c_end;

endmodule

// File: rtl/matrix_stream_ram.sv
// M x N matrix memory with a random-access port and a streaming read engine
// that emits the whole matrix row-major or transposed over valid/ready.
module matrix_stream_ram
  import matrix_mem_pkg::*;
#(
  parameter  int DW = 8,
  parameter  int M  = 8,
  parameter  int N  = 8,
  localparam int AW = addr_w(M, N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ramEN,
  input  logic          writeEN,
  input  logic          readEN,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          rdValid,
  output logic          addrErr,
  output logic          rdDropped,
  input  logic          startStream,
  input  logic          transpose,
  output logic          busy,
  output logic [DW-1:0] streamData,
  output logic          streamValid,
  input  logic          streamReady,
  output logic          streamLast
);

  localparam int DEPTH = M * N;

  logic [DW-1:0] mem [DEPTH];

  eng_state_t    state;
  eng_state_t    state_nxt;

  logic          in_range;
  logic          wr_en;
  logic          rd_req;
  logic          rd_ok;
  logic          access;
  logic [AW-1:0] port_addr;

  logic          gen_clear;
  logic          gen_last;
  logic [AW-1:0] gen_addr;

  logic [DW-1:0] skid_data [2];
  logic [1:0]    skid_last;
  logic          wptr;
  logic          rptr;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;

  assign in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
  assign access   = ramEN & (writeEN | readEN);
  assign wr_en    = ramEN & writeEN & in_range;
  assign rd_req   = ramEN & readEN & ~writeEN;
  assign rd_ok    = rd_req & ~busy & in_range;

  assign busy        = (state != IDLE);
  assign streamValid = (occ != 2'd0);
  assign streamData  = skid_data[rptr];
  assign streamLast  = skid_last[rptr] & streamValid;
  assign pop         = streamValid & streamReady;

  // The RAM read lands directly in the skid entry, so an issued read is
  // already counted in occ on the following cycle; credit is occ after pop.
  assign issue = (state == RUN) && (({1'b0, occ} - {2'b0, pop}) < 3'd2);

  // Random reads are only granted while idle, so the single read port is
  // owned by the engine whenever it is busy.
  assign port_addr = busy ? gen_addr : addr;
  assign gen_clear = (state == IDLE) & startStream;

  matrix_addr_gen #(
    .M (M),
    .N (N)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (gen_clear),
    .transpose (transpose),
    .advance   (issue),
    .addr      (gen_addr),
    .last      (gen_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (startStream) state_nxt = RUN;
      RUN:     if (issue && gen_last) state_nxt = DRAIN;
      DRAIN:   if (pop && streamLast && occ == 2'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Storage is never reset; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      rdValid   <= 1'b0;
      addrErr   <= 1'b0;
      rdDropped <= 1'b0;
    end else begin
      if (rd_ok) data_out <= mem[port_addr];
      rdValid   <= rd_ok;
      addrErr   <= access & ~in_range;
      rdDropped <= rd_req & busy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last    <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      occ          <= 2'd0;
    end else begin
      if (issue) begin
        skid_data[wptr] <= mem[port_addr];
        skid_last[wptr] <= gen_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, issue} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_matrix_stream_ram.sv
// Scoreboard bench for matrix_stream_ram: 4x4 main instance plus a 3x5
// instance whose address space leaves room for out-of-range accesses.
module tb_matrix_stream_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       ramEN, writeEN, readEN, startStream, transpose, streamReady;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out, streamData;
  logic       rdValid, addrErr, rdDropped, busy, streamValid, streamLast;

  logic       s_ramEN, s_writeEN, s_readEN;
  logic [3:0] s_addr;
  logic [7:0] s_data_in, s_data_out, s_streamData;
  logic       s_rdValid, s_addrErr, s_rdDropped, s_busy, s_streamValid, s_streamLast;

  int         total = 0;
  int         bad   = 0;
  int         beats = 0;
  bit         mon_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] held_data;
  logic [7:0] model [16];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  matrix_stream_ram #(.DW(8), .M(4), .N(4)) dut (
    .clk(clk), .rst(rst), .ramEN(ramEN), .writeEN(writeEN), .readEN(readEN),
    .addr(addr), .data_in(data_in), .data_out(data_out), .rdValid(rdValid),
    .addrErr(addrErr), .rdDropped(rdDropped), .startStream(startStream),
    .transpose(transpose), .busy(busy), .streamData(streamData),
    .streamValid(streamValid), .streamReady(streamReady), .streamLast(streamLast)
  );

  matrix_stream_ram #(.DW(8), .M(3), .N(5)) u_small (
    .clk(clk), .rst(rst), .ramEN(s_ramEN), .writeEN(s_writeEN), .readEN(s_readEN),
    .addr(s_addr), .data_in(s_data_in), .data_out(s_data_out), .rdValid(s_rdValid),
    .addrErr(s_addrErr), .rdDropped(s_rdDropped), .startStream(1'b0),
    .transpose(1'b0), .busy(s_busy), .streamData(s_streamData),
    .streamValid(s_streamValid), .streamReady(1'b1), .streamLast(s_streamLast)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},  {24'b0, data_out},   0);
    chk({tag, "_rdv"},   {31'b0, rdValid},    0);
    chk({tag, "_aerr"},  {31'b0, addrErr},    0);
    chk({tag, "_rdrop"}, {31'b0, rdDropped},  0);
    chk({tag, "_busy"},  {31'b0, busy},       0);
    chk({tag, "_sval"},  {31'b0, streamValid}, 0);
    chk({tag, "_slast"}, {31'b0, streamLast}, 0);
    chk({tag, "_sdata"}, {24'b0, streamData}, 0);
  endtask

  // Beat checker: pops the scoreboard on each handshake, checks hold on stall.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev && streamValid) chk("stall_hold", {24'b0, streamData}, {24'b0, held_data});
      stall_prev = streamValid && !streamReady;
      held_data  = streamData;
      if (streamValid && streamReady) begin
        if (exp_q.size() == 0) chk("extra_beat", {31'b0, streamValid}, 0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("sdata", {24'b0, streamData}, {24'b0, e[7:0]});
          chk("slast", {31'b0, streamLast}, {31'b0, e[8]});
          beats++;
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Pushes the expected sequence, pulses startStream, then flips transpose
  // to show it is only sampled at start.
  task automatic start_stream(input bit tr);
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = tr ? (i % 4) : (i / 4);
      c = tr ? (i / 4) : (i % 4);
      exp_q.push_back({(i == 15), model[r * 4 + c]});
    end
    startStream = 1'b1;
    transpose   = tr;
    tick();
    startStream = 1'b0;
    transpose   = ~tr;
    chk("busy_rise", {31'b0, busy}, 1);
    chk("first_val_early", {31'b0, streamValid}, 0);
  endtask

  task automatic drain(input int rmode, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      streamReady = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("busy_fall", {31'b0, busy}, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; ramEN = 0; writeEN = 0; readEN = 0; addr = 0; data_in = 0;
    startStream = 0; transpose = 0; streamReady = 1;
    s_ramEN = 0; s_writeEN = 0; s_readEN = 0; s_addr = 0; s_data_in = 0;
    tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      ramEN = 1; writeEN = 1; addr = 4'(k); data_in = 8'(k + 16);
      model[k] = 8'(k + 16);
      tick();
    end
    writeEN = 0; readEN = 1; addr = 4'd5;
    tick();
    ramEN = 0; readEN = 0;
    chk("rd5_data", {24'b0, data_out}, 21);
    chk("rd5_valid", {31'b0, rdValid}, 1);
    tick();
    chk("rd_valid_pulse", {31'b0, rdValid}, 0);
    chk("rd_hold", {24'b0, data_out}, 21);

    mon_en = 1'b1;
    start_stream(1'b0);
    drain(0, cyc);
    chk("row_cycles", cyc, 17);

    start_stream(1'b1);
    drain(0, cyc);
    chk("col_cycles", cyc, 17);

    start_stream(1'b1);
    drain(1, cyc);

    // Stalled stream: dropped read, ignored restart, write ahead of the engine.
    streamReady = 1'b0;
    model[15] = 8'hAA;
    start_stream(1'b0);
    tick(); tick(); tick();
    ramEN = 1; readEN = 1; addr = 4'd3;
    tick();
    ramEN = 0; readEN = 0;
    chk("drop_pulse", {31'b0, rdDropped}, 1);
    chk("drop_novalid", {31'b0, rdValid}, 0);
    chk("drop_dout_hold", {24'b0, data_out}, 21);
    startStream = 1'b1;
    tick();
    startStream = 1'b0;
    chk("drop_clear", {31'b0, rdDropped}, 0);
    ramEN = 1; writeEN = 1; addr = 4'd15; data_in = 8'hAA;
    tick();
    ramEN = 0; writeEN = 0;
    drain(1, cyc);

    s_ramEN = 1; s_writeEN = 1; s_addr = 4'd14; s_data_in = 8'h3C;
    tick();
    s_writeEN = 0; s_readEN = 1;
    tick();
    chk("s_rd14", {24'b0, s_data_out}, 8'h3C);
    chk("s_rd14_err", {31'b0, s_addrErr}, 0);
    s_readEN = 0; s_writeEN = 1; s_addr = 4'd15; s_data_in = 8'h55;
    tick();
    chk("s_wr_oor_err", {31'b0, s_addrErr}, 1);
    s_writeEN = 0; s_readEN = 1;
    tick();
    chk("s_rd_oor_err", {31'b0, s_addrErr}, 1);
    chk("s_rd_oor_nov", {31'b0, s_rdValid}, 0);
    chk("s_rd_oor_hold", {24'b0, s_data_out}, 8'h3C);
    s_ramEN = 0; s_readEN = 0;
    tick();
    chk("s_err_clear", {31'b0, s_addrErr}, 0);

    // Abandon a stream after 5 beats, then restart from element 0.
    streamReady = 1'b1;
    beats = 0;
    start_stream(1'b0);
    cyc = 0;
    while (beats < 5 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("mid_beats", beats, 5);
    streamReady = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    streamReady = 1'b1;
    mon_en = 1'b1;
    start_stream(1'b0);
    drain(0, cyc);
    chk("restart_cycles", cyc, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
